sha_search_engine: RTL and testbench

//  Next-generation mining search engine: NCORE sha_core instances sweep a host-given nonce range
//  [nonce_start, nonce_end] for one job (midState/headData), queueing every hit in a result FIFO.

---
 rtl/sha_pkg.sv | 23 ++
 rtl/sha_search_engine_if.sv | 43 ++++
 rtl/sha_core.sv | 29 ++
 rtl/sha_result_fifo.sv | 51 +++++
 rtl/sha_search_engine.sv | 184 ++++++++++++++++++
 tb/tb_sha_search_engine.sv | 234 +++++++++++++++++++++++
 6 files changed

// File: rtl/sha_pkg.sv
// Shared types and widths for the nonce search engine, its result FIFO and the hashing cores.
package sha_pkg;

  localparam int unsigned ROUNDS_DEF = 64;
  localparam int unsigned NONCE_W    = 32;
  localparam int unsigned MID_W      = 256;
  localparam int unsigned HEAD_W     = 512;
  localparam int unsigned HASH_CNT_W = 48;

  typedef logic [NONCE_W-1:0] nonce_t;

  typedef struct packed {
    logic   hit;
    nonce_t nonce;
  } core_out_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } search_state_t;

endpackage

// File: rtl/sha_search_engine_if.sv
// Host-side job / result bus of sha_search_engine.
// hash_count is present only when SHA_HASH_COUNT_EN is defined.
interface sha_search_engine_if #(
  parameter int unsigned FIFO_DEPTH = 8
);
  import sha_pkg::*;

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic               job_valid;
  logic               job_ready;
  logic [MID_W-1:0]   midState;
  logic [HEAD_W-1:0]  headData;
  nonce_t             nonce_start;
  nonce_t             nonce_end;
  logic               abort;
  logic               busy;
  logic               done;
  logic               res_valid;
  nonce_t             res_nonce;
  logic               res_ready;
  logic [CNT_W-1:0]   res_count;
`ifdef SHA_HASH_COUNT_EN
  logic [HASH_CNT_W-1:0] hash_count;
`endif

  modport master (
    output job_valid, midState, headData, nonce_start, nonce_end, abort, res_ready,
    input  job_ready, busy, done, res_valid, res_nonce, res_count
`ifdef SHA_HASH_COUNT_EN
    , input hash_count
`endif
  );

  modport slave (
    input  job_valid, midState, headData, nonce_start, nonce_end, abort, res_ready,
    output job_ready, busy, done, res_valid, res_nonce, res_count
`ifdef SHA_HASH_COUNT_EN
    , output hash_count
`endif
  );

endinterface

// File: rtl/sha_core.sv
// Per-nonce hashing core interface model: registered verdict one cycle after the nonce.
// A nonce hits when (nonce & header word 1) == header word 0 and all other job words XOR to zero.
module sha_core
  import sha_pkg::*;
(
  input  logic              clk,
  input  logic              n_rst,
  input  logic [MID_W-1:0]  midState,
  input  logic [HEAD_W-1:0] headData,
  input  nonce_t            nonce,
  output core_out_t         coreOutput
);

  logic [31:0] salt;
  logic        hit_c;

  always_comb begin
    salt = '0;
    for (int w = 0; w < 8; w++)  salt = salt ^ midState[w*32 +: 32];
    for (int w = 2; w < 16; w++) salt = salt ^ headData[w*32 +: 32];
    hit_c = ((nonce & headData[63:32]) == headData[31:0]) && (salt == '0);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) coreOutput <= '0;
    else        coreOutput <= {hit_c, nonce};
  end

endmodule

// File: rtl/sha_result_fifo.sv
// Golden-nonce result FIFO; push on full is legal only with a same-cycle pop, pop on empty is ignored.
module sha_result_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = empty ? '0 : mem[rd_ptr];
  assign count    = cnt;

endmodule

// File: rtl/sha_search_engine.sv
// Nonce-range search engine: NCORE sha_core instances sweep [nonce_start, nonce_end], hits queued in a FIFO.
// Optional SHA_HASH_COUNT_EN adds the 48-bit in-range hash counter on the bus.
module sha_search_engine
  import sha_pkg::*;
#(
  parameter int unsigned NCORE      = 4,
  parameter int unsigned ROUNDS     = ROUNDS_DEF,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic               clk,
  input  logic               n_rst,
  sha_search_engine_if.slave bus
);

  localparam int unsigned CYC_W  = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam int unsigned IDX_W  = (NCORE > 1) ? $clog2(NCORE) : 1;
  localparam int unsigned BASE_W = NONCE_W + 1;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(ROUNDS - 1);

  search_state_t      state;
  search_state_t      state_d;
  logic               job_ready_q;
  logic               busy_q;
  logic               done_q;

  logic [CYC_W-1:0]   cycle;
  logic [BASE_W-1:0]  base;
  logic [BASE_W-1:0]  base_adv;
  nonce_t             end_q;
  logic [MID_W-1:0]   mid_q;
  logic [HEAD_W-1:0]  head_q;

  logic [NCORE-1:0]   pending;
  logic [NCORE-1:0]   pending_d;
  logic [NCORE-1:0]   in_range;
  logic [NCORE-1:0]   hit_vec;
  nonce_t             cap_nonce [NCORE];
  core_out_t          core_out  [NCORE];
  logic [IDX_W-1:0]   sel;

  logic               accept;
  logic               abort_run;
  logic               last_cyc;
  logic               batch_end;
  logic               push;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  nonce_t             fifo_head;
  logic [CNT_W-1:0]   fifo_count;

  // Core i hashes base+i; the 33-bit sum keeps the range test exact at the top of the nonce space.
  for (genvar i = 0; i < NCORE; i++) begin : g_core
    logic [BASE_W-1:0] nonce_wide;
    assign nonce_wide  = base + BASE_W'(i);
    assign in_range[i] = (nonce_wide <= {1'b0, end_q});
    assign hit_vec[i]  = core_out[i].hit & in_range[i];

    sha_core u_core (
      .clk        (clk),
      .n_rst      (n_rst),
      .midState   (mid_q),
      .headData   (head_q),
      .nonce      (nonce_wide[NONCE_W-1:0]),
      .coreOutput (core_out[i])
    );
  end

  assign accept    = (state == IDLE) && bus.job_valid;
  assign abort_run = (state == RUN) && bus.abort;
  assign last_cyc  = (cycle == LAST_CYC);
  assign batch_end = (state == RUN) && !bus.abort && last_cyc && (pending == '0);
  assign base_adv  = base + BASE_W'(NCORE);
  assign pop       = bus.res_ready && !fifo_empty;
  assign push      = (pending != '0) && (!fifo_full || pop) && !abort_run;

  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (accept) state_d = (bus.nonce_start > bus.nonce_end) ? DONE : RUN;
      RUN: begin
        if (bus.abort) state_d = DONE;
        else if (batch_end && (base_adv > {1'b0, end_q})) state_d = DONE;
      end
      DONE: if (pending == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= IDLE;
      job_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state       <= state_d;
      job_ready_q <= (state_d == IDLE);
      busy_q      <= (state_d == RUN);
      done_q      <= (state == DONE) && (pending == '0);
    end
  end

  // Drain picks the lowest pending core; a & (a-1) clears exactly that bit.
  always_comb begin
    sel = '0;
    for (int i = NCORE - 1; i >= 0; i--) begin
      if (pending[i]) sel = IDX_W'(i);
    end
    pending_d = pending;
    if (push) pending_d = pending & (pending - NCORE'(1));
    if (abort_run)      pending_d = '0;
    else if (batch_end) pending_d = hit_vec;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cycle   <= '0;
      base    <= '0;
      end_q   <= '0;
      mid_q   <= '0;
      head_q  <= '0;
      pending <= '0;
      for (int i = 0; i < NCORE; i++) cap_nonce[i] <= '0;
    end else begin
      pending <= pending_d;
      if (accept) begin
        base   <= {1'b0, bus.nonce_start};
        cycle  <= '0;
        end_q  <= bus.nonce_end;
        mid_q  <= bus.midState;
        head_q <= bus.headData;
      end else if (batch_end) begin
        base  <= base_adv;
        cycle <= '0;
        for (int i = 0; i < NCORE; i++) cap_nonce[i] <= core_out[i].nonce;
      end else if ((state == RUN) && !bus.abort && !last_cyc) begin
        cycle <= cycle + CYC_W'(1);
      end
    end
  end

  sha_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (NONCE_W)
  ) u_fifo (
    .clk       (clk),
    .n_rst     (n_rst),
    .push      (push),
    .push_data (cap_nonce[sel]),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

`ifdef SHA_HASH_COUNT_EN
  logic [HASH_CNT_W-1:0] hash_count_q;
  logic [HASH_CNT_W-1:0] inr_cnt;

  always_comb begin
    inr_cnt = '0;
    for (int i = 0; i < NCORE; i++) inr_cnt = inr_cnt + HASH_CNT_W'(in_range[i]);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)         hash_count_q <= '0;
    else if (accept)    hash_count_q <= '0;
    else if (batch_end) hash_count_q <= hash_count_q + inr_cnt;
  end

  assign bus.hash_count = hash_count_q;
`endif

  assign bus.job_ready = job_ready_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.res_valid = !fifo_empty;
  assign bus.res_nonce = fifo_head;
  assign bus.res_count = fifo_count;

endmodule

// File: tb/tb_sha_search_engine.sv
// Directed bench for sha_search_engine: NCORE=4, ROUNDS=64, FIFO_DEPTH=2.
module tb_sha_search_engine;

  logic clk;
  logic n_rst;
  int   tests;
  int   fails;

  sha_search_engine_if #(.FIFO_DEPTH(2)) bus ();

  sha_search_engine #(
    .NCORE      (4),
    .ROUNDS     (64),
    .FIFO_DEPTH (2)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Offer a job for one edge; hits are nonces with (nonce & mask) == match.
  task automatic start_job(input logic [31:0] s, input logic [31:0] e,
                           input logic [31:0] mask, input logic [31:0] match);
    bus.midState       = '0;
    bus.headData       = '0;
    bus.headData[31:0] = match;
    bus.headData[63:32]= mask;
    bus.nonce_start    = s;
    bus.nonce_end      = e;
    bus.job_valid      = 1'b1;
    @(posedge clk); #1;
    bus.job_valid      = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!bus.done && n < max_cyc);
    if (!bus.done) n = -1;
  endtask

  task automatic pop_one();
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    int          k;
    bit          done_seen;
    logic [31:0] got [4];
    logic [31:0] exp_nonce;

    tests = 0;
    fails = 0;
    n_rst = 1'b0;
    bus.job_valid = 1'b0;
    bus.midState = '0;
    bus.headData = '0;
    bus.nonce_start = '0;
    bus.nonce_end = '0;
    bus.abort = 1'b0;
    bus.res_ready = 1'b0;

    #7;
    check_eq("rst_job_ready", bus.job_ready, 1);
    check_eq("rst_busy",      bus.busy, 0);
    check_eq("rst_done",      bus.done, 0);
    check_eq("rst_res_valid", bus.res_valid, 0);
    check_eq("rst_res_nonce", bus.res_nonce, 0);
    check_eq("rst_res_count", bus.res_count, 0);
    @(negedge clk) n_rst = 1'b1;
    @(posedge clk); #1;

    // Single hit at 0x105 inside a 64-batch range.
    start_job(32'h100, 32'h1FF, 32'hFFFF_FFFF, 32'h105);
    check_eq("t1_busy",      bus.busy, 1);
    check_eq("t1_job_ready", bus.job_ready, 0);
    wait_done(5000, n);
    check_eq("t1_done_cycles", n, 4097);
    check_eq("t1_res_count",   bus.res_count, 1);
    check_eq("t1_res_nonce",   bus.res_nonce, 32'h105);
    check_eq("t1_ready_after", bus.job_ready, 1);
`ifdef SHA_HASH_COUNT_EN
    check_eq("t1_hash_count", bus.hash_count, 256);
`endif
    pop_one();
    check_eq("t1_empty", bus.res_valid, 0);

    // Four hits in one batch against a 2-deep FIFO: stall, then release in order.
    start_job(32'h200, 32'h20B, 32'hFFFF_FFFC, 32'h200);
    done_seen = 1'b0;
    repeat (200) begin
      @(posedge clk); #1;
      if (bus.done) done_seen = 1'b1;
    end
    check_eq("t2_no_done_stall", done_seen, 0);
    check_eq("t2_busy_stall",    bus.busy, 1);
    check_eq("t2_count_full",    bus.res_count, 2);
    check_eq("t2_head_stall",    bus.res_nonce, 32'h200);
`ifdef SHA_HASH_COUNT_EN
    check_eq("t2_hash_stall", bus.hash_count, 4);
`endif
    bus.res_ready = 1'b1;
    k = 0;
    n = 0;
    while (k < 4 && n < 20) begin
      if (bus.res_valid) begin
        got[k] = bus.res_nonce;
        k++;
      end
      @(posedge clk); #1;
      n++;
    end
    bus.res_ready = 1'b0;
    check_eq("t2_result_cnt", k, 4);
    for (int i = 0; i < 4; i++) begin
      exp_nonce = 32'h200 + 32'(i);
      check_eq($sformatf("t2_result%0d", i), got[i], exp_nonce);
    end
    wait_done(400, n);
    check_eq("t2_done_seen", (n > 0), 1);
    check_eq("t2_count_end", bus.res_count, 0);
`ifdef SHA_HASH_COUNT_EN
    check_eq("t2_hash_end", bus.hash_count, 12);
`endif

    // Hit at 0x13 lies past nonce_end and must be masked.
    start_job(32'h10, 32'h12, 32'hFFFF_FFFF, 32'h13);
    wait_done(200, n);
    check_eq("t3_done_cycles", n, 65);
    check_eq("t3_res_count",   bus.res_count, 0);
`ifdef SHA_HASH_COUNT_EN
    check_eq("t3_hash_count", bus.hash_count, 3);
`endif

    // Top of nonce space: one batch, hit on the last nonce, no wrap.
    start_job(32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(200, n);
    check_eq("t4_done_cycles", n, 66);
    check_eq("t4_res_count",   bus.res_count, 1);
    check_eq("t4_res_nonce",   bus.res_nonce, 32'hFFFF_FFFF);
`ifdef SHA_HASH_COUNT_EN
    check_eq("t4_hash_count", bus.hash_count, 4);
`endif
    pop_one();

    // Empty range: straight to DONE.
    start_job(32'h50, 32'h40, 32'hFFFF_FFFF, 32'h45);
    check_eq("t5_busy",      bus.busy, 0);
    check_eq("t5_job_ready", bus.job_ready, 0);
    wait_done(10, n);
    check_eq("t5_done_cycles", n, 1);
    check_eq("t5_res_count",   bus.res_count, 0);
`ifdef SHA_HASH_COUNT_EN
    check_eq("t5_hash_count", bus.hash_count, 0);
`endif

    // Abort at cycle 10 of batch 3; hit from batch 2 survives.
    start_job(32'h300, 32'h3FF, 32'hFFFF_FFFF, 32'h304);
    repeat (138) begin @(posedge clk); #1; end
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    check_eq("t6_busy_abort", bus.busy, 0);
    check_eq("t6_done_early", bus.done, 0);
    wait_done(10, n);
    check_eq("t6_done_cycles", n, 1);
    check_eq("t6_job_ready",   bus.job_ready, 1);
    check_eq("t6_res_count",   bus.res_count, 1);
    check_eq("t6_res_nonce",   bus.res_nonce, 32'h304);
`ifdef SHA_HASH_COUNT_EN
    check_eq("t6_hash_count", bus.hash_count, 8);
`endif
    pop_one();

    // Abort while idle is ignored.
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    check_eq("t6_idle_abort_ready", bus.job_ready, 1);
    check_eq("t6_idle_abort_done",  bus.done, 0);

    // Next job after abort; hit in the final batch delays done by the drain.
    start_job(32'h400, 32'h407, 32'hFFFF_FFFF, 32'h406);
    wait_done(300, n);
    check_eq("t6b_done_cycles", n, 130);
    check_eq("t6b_res_nonce",   bus.res_nonce, 32'h406);
    pop_one();

    // Asynchronous reset mid-run with a queued result.
    start_job(32'h500, 32'h5FF, 32'hFFFF_FFFF, 32'h501);
    repeat (70) begin @(posedge clk); #1; end
    check_eq("t7_pre_count", bus.res_count, 1);
    #2 n_rst = 1'b0;
    #1;
    check_eq("t7_job_ready", bus.job_ready, 1);
    check_eq("t7_busy",      bus.busy, 0);
    check_eq("t7_done",      bus.done, 0);
    check_eq("t7_res_valid", bus.res_valid, 0);
    check_eq("t7_res_nonce", bus.res_nonce, 0);
    check_eq("t7_res_count", bus.res_count, 0);
`ifdef SHA_HASH_COUNT_EN
    check_eq("t7_hash_count", bus.hash_count, 0);
`endif
    @(negedge clk) n_rst = 1'b1;
    @(posedge clk); #1;
    check_eq("t7_ready_post", bus.job_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
